cola_dispense: RTL and testbench

- Consumer end of the vending controller's dispense output. Accepts single-cycle dispense-request pulses of the kind the coin/cola controller emits.
- Queues requests in a saturating pending counter, runs the dispense motor for a fixed number of cycles per can, then confirms delivery via a drop sensor.
- Raises a latched fault if no can is seen within a timeout window.
- Sits between the vending FSM and the motor/sensor pads.

---
 rtl/cola_pkg.sv | 15 +
 rtl/cola_rise_det.sv | 18 +
 rtl/cola_dispense.sv | 132 +++++++++++++
 tb/tb_cola_dispense.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cola_pkg.sv
// rtl/cola_pkg.sv - shared states and default timing for the cola dispenser
package cola_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    WAIT  = 4'b0100,
    FAULT = 4'b1000
  } state_t;

  localparam int MOTOR_CYC_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 32;
  localparam int PEND_W_DEF      = 3;

endpackage

// File: rtl/cola_rise_det.sv
// rtl/cola_rise_det.sv - 1-bit rising-edge detector
module cola_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/cola_dispense.sv
// rtl/cola_dispense.sv - queued can dispenser: motor burst, drop confirm, timeout fault
module cola_dispense
  import cola_pkg::*;
#(
  parameter int MOTOR_CYC   = MOTOR_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int PEND_W      = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pi_cola,
  input  logic              pi_drop,
  input  logic              pi_clr_fault,
  output logic              po_motor,
  output logic              po_busy,
  output logic              po_done,
  output logic              po_fault,
  output logic              po_lost,
  output logic [PEND_W-1:0] po_pend
);

  localparam int MW = (MOTOR_CYC > 1) ? $clog2(MOTOR_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [MW-1:0]     MCNT_LAST = MW'(MOTOR_CYC - 1);
  localparam logic [TW-1:0]     TCNT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t            state;
  logic [MW-1:0]     mcnt;
  logic [TW-1:0]     tcnt;
  logic              seen;
  logic [PEND_W-1:0] pend;
  logic              drop_rise;
  logic              inc;
  logic              dec;

  cola_rise_det u_drop_det (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (pi_drop),
    .rise (drop_rise)
  );

  assign inc     = pi_cola;
  assign dec     = (state == IDLE) && (pend != '0);
  assign po_pend = pend;

  // Requests are taken in every state; a full counter drops the request and flags it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      po_lost <= 1'b0;
    end else begin
      po_lost <= 1'b0;
      if (inc && !dec) begin
        if (pend == PEND_MAX) po_lost <= 1'b1;
        else                  pend    <= pend + 1'b1;
      end else if (dec && !inc) begin
        pend <= pend - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcnt     <= '0;
      tcnt     <= '0;
      seen     <= 1'b0;
      po_motor <= 1'b0;
      po_busy  <= 1'b0;
      po_done  <= 1'b0;
      po_fault <= 1'b0;
    end else begin
      po_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend != '0) begin
            state    <= RUN;
            mcnt     <= '0;
            seen     <= 1'b0;
            po_motor <= 1'b1;
            po_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (mcnt == MCNT_LAST) begin
            po_motor <= 1'b0;
            // An edge during the burst already confirms the can.
            if (seen || drop_rise) begin
              state   <= IDLE;
              po_busy <= 1'b0;
              po_done <= 1'b1;
            end else begin
              state <= WAIT;
              tcnt  <= '0;
            end
          end else begin
            mcnt <= mcnt + 1'b1;
            seen <= seen | drop_rise;
          end
        end
        WAIT: begin
          if (drop_rise) begin
            state   <= IDLE;
            po_busy <= 1'b0;
            po_done <= 1'b1;
          end else if (tcnt == TCNT_LAST) begin
            state    <= FAULT;
            po_fault <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FAULT: begin
          if (pi_clr_fault) begin
            state    <= IDLE;
            po_busy  <= 1'b0;
            po_fault <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          po_motor <= 1'b0;
          po_busy  <= 1'b0;
          po_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cola_dispense.sv
// tb/tb_cola_dispense.sv - directed self-checking bench for cola_dispense
module tb_cola_dispense;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pi_cola;
  logic       pi_drop;
  logic       pi_clr_fault;
  logic       po_motor;
  logic       po_busy;
  logic       po_done;
  logic       po_fault;
  logic       po_lost;
  logic [2:0] po_pend;

  int passed = 0;
  int total  = 0;

  int   rise_idx [3];
  int   nrise, ndone, nmotor, done_idx, pend_s2, wcnt;
  logic pm, was_wait;

  cola_dispense dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pi_cola     (pi_cola),
    .pi_drop     (pi_drop),
    .pi_clr_fault(pi_clr_fault),
    .po_motor    (po_motor),
    .po_busy     (po_busy),
    .po_done     (po_done),
    .po_fault    (po_fault),
    .po_lost     (po_lost),
    .po_pend     (po_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pi_cola = 0; pi_drop = 0; pi_clr_fault = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; pi_cola = 0; pi_drop = 0; pi_clr_fault = 0;
    @(negedge clk);
    tick();
    check("rst_motor", po_motor, 0);
    check("rst_busy",  po_busy,  0);
    check("rst_done",  po_done,  0);
    check("rst_fault", po_fault, 0);
    check("rst_lost",  po_lost,  0);
    check("rst_pend",  po_pend,  0);
    rst_n = 1;

    // single request, drop edge early in the burst
    pi_cola = 1; tick(); pi_cola = 0;
    check("t1_pend_after_e0", po_pend, 1);
    check("t1_motor_after_e0", po_motor, 0);
    nmotor = 0; ndone = 0; done_idx = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (po_motor) nmotor++;
      if (po_done) begin ndone++; done_idx = i; end
      if (i == 0) check("t1_pend_run", po_pend, 0);
      if (i == 8) check("t1_busy_after", po_busy, 0);
      if (i == 2) pi_drop = 1;
    end
    pi_drop = 0;
    check("t1_motor_cycles", nmotor, 8);
    check("t1_done_count", ndone, 1);
    check("t1_done_idx", done_idx, 8);

    // three back-to-back requests, drop edge in each WAIT
    nrise = 0; ndone = 0; pend_s2 = -1; pm = 0; was_wait = 0;
    rise_idx = '{-1, -1, -1};
    for (int i = 0; i < 40; i++) begin
      pi_cola = (i < 3);
      pi_drop = was_wait;
      tick();
      if (po_motor && !pm) begin
        if (nrise < 3) rise_idx[nrise] = i;
        nrise++;
      end
      pm = po_motor;
      if (po_done) ndone++;
      if (i == 2) pend_s2 = po_pend;
      was_wait = po_busy && !po_motor && !po_fault;
    end
    pi_cola = 0; pi_drop = 0;
    check("t2_pend_peak", pend_s2, 2);
    check("t2_bursts", nrise, 3);
    check("t2_rise0", rise_idx[0], 1);
    check("t2_rise1", rise_idx[1], 11);
    check("t2_rise2", rise_idx[2], 21);
    check("t2_dones", ndone, 3);
    check("t2_pend_end", po_pend, 0);

    // timeout into FAULT, requests while faulted, clear
    pi_cola = 1; tick(); pi_cola = 0;
    wcnt = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (po_fault) break;
      if (po_busy && !po_motor) wcnt++;
    end
    check("t3_wait_len", wcnt, 32);
    check("t3_fault", po_fault, 1);
    check("t3_busy", po_busy, 1);
    check("t3_motor_off", po_motor, 0);
    pi_cola = 1; tick(); tick(); pi_cola = 0;
    check("t3_pend_fault", po_pend, 2);
    check("t3_still_fault", po_fault, 1);
    pi_clr_fault = 1; tick(); pi_clr_fault = 0;
    check("t3_clr_fault", po_fault, 0);
    check("t3_clr_busy", po_busy, 0);
    check("t3_clr_pend", po_pend, 2);
    tick();
    check("t3_resume_motor", po_motor, 1);
    check("t3_resume_pend", po_pend, 1);
    do_reset();

    // saturation: lost request at pend==7, then simultaneous inc/dec at 7
    pi_cola = 1;
    for (int i = 0; i < 8; i++) tick();
    check("t4_pend7", po_pend, 7);
    check("t4_no_lost_yet", po_lost, 0);
    tick();
    check("t4_lost", po_lost, 1);
    check("t4_pend_sat", po_pend, 7);
    pi_cola = 0; pi_drop = 1; tick();
    check("t4_lost_clear", po_lost, 0);
    check("t4_done", po_done, 1);
    check("t4_idle", po_busy, 0);
    pi_cola = 1; pi_drop = 0; tick(); pi_cola = 0;
    check("t4_incdec_pend", po_pend, 7);
    check("t4_incdec_lost", po_lost, 0);
    check("t4_incdec_motor", po_motor, 1);
    do_reset();

    // async reset in the middle of a burst
    pi_cola = 1; tick(); tick(); tick(); pi_cola = 0;
    tick(); tick(); tick();
    check("t5_motor_pre", po_motor, 1);
    check("t5_pend_pre", po_pend, 2);
    #2 rst_n = 0;
    #1;
    check("t5_motor_async", po_motor, 0);
    check("t5_busy_async", po_busy, 0);
    check("t5_pend_async", po_pend, 0);
    @(negedge clk);
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (po_done || po_busy) ndone++;
    end
    check("t5_quiet_after", ndone, 0);
    check("t5_pend_after", po_pend, 0);

    // stray drop edge in IDLE is not credited
    pi_drop = 1; tick(); pi_drop = 0;
    pi_cola = 1; tick(); pi_cola = 0;
    for (int i = 0; i < 9; i++) tick();
    check("t6_wait_busy", po_busy, 1);
    check("t6_wait_motor", po_motor, 0);
    check("t6_wait_fault", po_fault, 0);
    pi_drop = 1; tick(); pi_drop = 0;
    check("t6_done", po_done, 1);
    check("t6_idle", po_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
